// File: rtl/cfm_poller.sv
// ---------------------------------------------------------------------------
// cfm_poller
//
// CFM-side initiator for the LCB RS485 link. When started, it sends a single
// 8N1 request byte with half-duplex direction control. It then collects an
// ANS_LEN-byte answer frame from the UART_RX byte stream and writes each byte
// into an external answer RAM. The block finishes with either a done pulse or
// a timeout pulse.
//
// Optional feature macro: CFM_POLLER_CHECKSUM_EN
//   When defined, the chk_err output is present. It is set together with done
//   when the XOR of all answer bytes is not 0x00, and it is cleared on the next
//   accepted start.
//
// Handshake semantics:
//   start/cmd  - single-cycle request. It is accepted only while busy=0.
//                cmd is captured on the accepted cycle. A start that arrives
//                while busy=1 is dropped, with no queueing.
//   rx_valid   - single-cycle strobe with no backpressure. It is used only in
//                RX_WAIT. A strobe in any other state (including the local
//                echo while dirTX=1) is discarded.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, cmd        request pulse and request byte
//   rx_valid, rx_data answer byte stream from UART_RX
//   tx                serial request line (idle high)
//   dirTX, dirRX      RS485 driver / receiver enables (dirRX = ~dirTX)
//   ans_we/addr/data  answer RAM write port
//   busy              high in every state except IDLE
//   done, timeout     single-cycle completion pulses
//   chk_err           (CFM_POLLER_CHECKSUM_EN only) frame XOR check failed
// ---------------------------------------------------------------------------
module cfm_poller #(
    parameter int BAUD_DIV   = 16,
    parameter int ANS_LEN    = 32,
    parameter int ADDR_W     = 5,
    parameter int GUARD_BITS = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        cmd,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx,
    output logic              dirTX,
    output logic              dirRX,
    output logic              ans_we,
    output logic [ADDR_W-1:0] ans_addr,
    output logic [7:0]        ans_data,
    output logic              busy,
    output logic              done,
    output logic              timeout
`ifdef CFM_POLLER_CHECKSUM_EN
    ,
    output logic              chk_err
`endif
);

    localparam int CNT_W   = ($clog2(BAUD_DIV) > 0) ? $clog2(BAUD_DIV) : 1;
    localparam int BIT_MAX = (GUARD_BITS > 10) ? GUARD_BITS : 10;
    localparam int BIT_W   = $clog2(BIT_MAX + 1);
    localparam int TMR_W   = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRE     = 3'd1,
        SHIFT   = 3'd2,
        GUARD   = 3'd3,
        RX_WAIT = 3'd4
    } state_t;

    state_t            state;
    logic [9:0]        frame_sr;   // {stop, cmd, start}, shifted out LSB first
    logic [CNT_W-1:0]  baud_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [ADDR_W-1:0] byte_idx;
    logic [TMR_W-1:0]  timer;
    logic              last_pend;  // final byte written this cycle, done follows
`ifdef CFM_POLLER_CHECKSUM_EN
    logic [7:0]        chk_acc;
`endif

    logic baud_end;
    assign baud_end = (baud_cnt == CNT_W'(BAUD_DIV - 1));

    // The receiver is enabled whenever the driver is off. dirRX is derived
    // from the registered dirTX, so the two can never be high together.
    assign dirRX = ~dirTX;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            frame_sr  <= '1;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            byte_idx  <= '0;
            timer     <= '0;
            last_pend <= 1'b0;
            tx        <= 1'b1;
            dirTX     <= 1'b0;
            ans_we    <= 1'b0;
            ans_addr  <= '0;
            ans_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
`ifdef CFM_POLLER_CHECKSUM_EN
            chk_acc   <= '0;
            chk_err   <= 1'b0;
`endif
        end else begin
            // These outputs are single-cycle strobes.
            ans_we  <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        frame_sr <= {1'b1, cmd, 1'b0};
                        state    <= PRE;
                        dirTX    <= 1'b1;
                        busy     <= 1'b1;
                        tx       <= 1'b1;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        ans_addr <= '0;
`ifdef CFM_POLLER_CHECKSUM_EN
                        chk_acc  <= '0;
                        chk_err  <= 1'b0;
`endif
                    end
                end

                // The driver is enabled and the line is held idle for one bit
                // time so the transceiver can settle before the start bit.
                PRE: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= frame_sr[0];
                        frame_sr <= {1'b1, frame_sr[9:1]};
                        state    <= SHIFT;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                // bit_cnt is the index of the frame bit currently on tx
                // (0 = start bit, 9 = stop bit).
                SHIFT: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_W'(9)) begin
                            bit_cnt <= '0;
                            tx      <= 1'b1;
                            if (GUARD_BITS == 0) begin
                                state     <= RX_WAIT;
                                dirTX     <= 1'b0;
                                timer     <= '0;
                                byte_idx  <= '0;
                                last_pend <= 1'b0;
                            end else begin
                                state <= GUARD;
                            end
                        end else begin
                            tx       <= frame_sr[0];
                            frame_sr <= {1'b1, frame_sr[9:1]};
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                GUARD: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_W'(GUARD_BITS - 1)) begin
                            bit_cnt   <= '0;
                            state     <= RX_WAIT;
                            dirTX     <= 1'b0;
                            timer     <= '0;
                            byte_idx  <= '0;
                            last_pend <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                // rx_valid takes priority over timer expiry. A byte that lands
                // on the last timer cycle is still accepted.
                RX_WAIT: begin
                    if (last_pend) begin
                        last_pend <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
`ifdef CFM_POLLER_CHECKSUM_EN
                        chk_err   <= |chk_acc;
`endif
                    end else if (rx_valid) begin
                        ans_we   <= 1'b1;
                        ans_addr <= byte_idx;
                        ans_data <= rx_data;
                        timer    <= '0;
                        byte_idx <= byte_idx + 1'b1;
`ifdef CFM_POLLER_CHECKSUM_EN
                        chk_acc  <= chk_acc ^ rx_data;
`endif
                        if (byte_idx == ADDR_W'(ANS_LEN - 1)) begin
                            last_pend <= 1'b1;
                        end
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    dirTX <= 1'b0;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
